axis_fifo_packer: RTL
=====================

Name: axis_fifo_packer

Overview:
- Write-side front end of the async FIFO: accepts a narrow AXI-Stream input (e.g. 32-bit configuration/bitstream words) in the wclk domain.
- Packs input beats into full-width words and drives the FIFO write port (wen/wdata/full).
- Absorbs FIFO backpressure through the AXIS tready handshake.
- Terminates a packet on tlast by padding the partially filled word, so no data remains stranded in the packer.

Parameters:
- DIN_WIDTH, 32, input beat width in bits.
- DOUT_WIDTH, 256, packed output width; must equal the FIFO WIDTH and be DIN_WIDTH × 2^k with k ≥ 1.
- PAD_WORD, 32'hFFFF_FFFF, DIN_WIDTH-wide value written into unused lanes of a word closed by tlast.

Ports:
- wclk  in  1  write-domain clock.
- wresetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  DIN_WIDTH  input beat.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tlast  in  1  last beat of packet.
- s_axis_tready  out  1  packer can accept a beat.
- fifo_wen  out  1  FIFO write strobe.
- fifo_wdata  out  DOUT_WIDTH  FIFO write data.
- fifo_full  in  1  FIFO full flag (registered in FIFO, wclk domain).
- word_cnt  out  32  count of words written to the FIFO; wraps.
- pkt_cnt  out  16  count of packets (words closed by tlast) written; wraps.

Behaviour:
- Reset is wresetn only, async assert, sync release to wclk. All outputs and state are 0 on reset, including s_axis_tready; any partial word is discarded. Reset mid-packet drops the packet and raises no error.
- RATIO = DOUT_WIDTH/DIN_WIDTH.
- Lane counter: LW = log2(RATIO) bits, reset 0.
- First beat of a word lands in bits [DIN_WIDTH-1:0], then ascending lanes.
- Registers: accumulator (acc), output register (out_q, out_v).
- FIFO write: fifo_wen = out_v & ~fifo_full. fifo_wdata = out_q whenever out_v.
- Drain: out_v clears on fifo_wen unless refilled in the same cycle.
- out_free = ~out_v | ~fifo_full.
- FSM FILL:
  - s_axis_tready = 1.
  - An accepted beat (tvalid & tready) writes lane[lane]; lane increments.
  - A beat with lane == RATIO-1 or with tlast closes the word. On tlast, lanes above the current one are filled with PAD_WORD.
  - Closed word and out_free: move the word into out_q, set out_v, clear lane, stay in FILL.
  - Closed word and not out_free: the word stays in acc; go to HOLD.
- FSM HOLD:
  - s_axis_tready = 0.
  - When out_free: move acc into out_q, clear lane, go to FILL.
- pkt_flag travels with each word. pkt_cnt increments on fifo_wen of a tlast-closed word; word_cnt increments on every fifo_wen.
- Latency: closing beat accepted at cycle N → fifo_wen at N+1 if fifo_full is 0.
- Throughput: one beat per cycle while the FIFO is not full.
- Ready gating:
  - s_axis_tready never depends combinationally on s_axis_tvalid.
  - In FILL it is registered-state only; fifo_full affects only the HOLD transfer, never the ready of the current beat.
- Simultaneous drain and refill: drain and refill of out_q in the same cycle is legal and keeps out_v = 1.
- Boundary cases:
  - tlast on lane RATIO-1: no padding.
  - tlast on lane 0: lanes 1..RATIO-1 are PAD_WORD.
  - fifo_full held indefinitely: at most one word in out_q plus one in acc; no beat is lost.
- Counters wrap modulo 2^width without saturation.

Optional Feature:
- Macro: PACKER_BSWAP_EN.
- Defined: each accepted s_axis_tdata is byte-reversed within DIN_WIDTH before lane insertion (ICAP byte order); PAD_WORD is not swapped.
- Undefined: data passes unmodified.
- Timing and handshake are identical in both builds.

Test Plan (DIN_WIDTH = 32, DOUT_WIDTH = 256):
- Eight beats 0x00000001..0x00000008, tlast on the 8th, fifo_full = 0 → one fifo_wen, one cycle after beat 8. fifo_wdata = {8,7,6,5,4,3,2,1} (lane 0 in LSBs). word_cnt = 1, pkt_cnt = 1.
- Three beats 0xA, 0xB, 0xC with tlast on 0xC → fifo_wdata = {5×0xFFFFFFFF, 0xC, 0xB, 0xA}. A subsequent packet starts at lane 0.
- fifo_full = 1 and 24 beats offered → first two words accepted (out_q + acc). s_axis_tready = 0 after the 16th beat and stays 0. After fifo_full drops, fifo_wen runs on two consecutive cycles, then streaming resumes with no loss or reorder.
- Continuous 64-beat stream with fifo_full = 0 → s_axis_tready stays 1 throughout; 8 fifo_wen pulses spaced 8 cycles apart; word_cnt = 8.
- wresetn asserted after 5 beats, then 8 new beats 0x10..0x17 → no fifo_wen for the partial word. The next word equals {0x17..0x10}; counters restart from 0.
- With PACKER_BSWAP_EN: input beat 0x11223344 appears as lane value 0x44332211.

Source files
------------

// File: rtl/axis_fifo_packer.sv
// axis_fifo_packer: packs narrow AXI-Stream beats into FIFO-width words,
// padding the last word of a packet; optional byte swap via PACKER_BSWAP_EN.
// Ports:
//   wclk, wresetn          write clock, async active-low reset
//   s_axis_tdata/tvalid/   input stream (DIN_WIDTH beats)
//   tlast/tready
//   fifo_wen/wdata/full    FIFO write port (DOUT_WIDTH words)
//   word_cnt, pkt_cnt      wrapping counts of words / tlast-closed words
module axis_fifo_packer #(
   parameter int DIN_WIDTH  = 32,
   parameter int DOUT_WIDTH = 256,
   parameter logic [DIN_WIDTH-1:0] PAD_WORD = 32'hFFFF_FFFF
) (
   input  logic                  wclk,
   input  logic                  wresetn,
   input  logic [DIN_WIDTH-1:0]  s_axis_tdata,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   output logic                  s_axis_tready,
   output logic                  fifo_wen,
   output logic [DOUT_WIDTH-1:0] fifo_wdata,
   input  logic                  fifo_full,
   output logic [31:0]           word_cnt,
   output logic [15:0]           pkt_cnt
);

   localparam int RATIO = DOUT_WIDTH / DIN_WIDTH;
   localparam int LW    = $clog2(RATIO);
   localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

   // INIT keeps tready low for a cycle after reset release.
   typedef enum logic [1:0] {
      ST_INIT,
      ST_FILL,
      ST_HOLD
   } state_e;

   // Async assert, sync release of the internal reset.
   logic [1:0] rst_sync_q;
   logic       rst_n;

   always_ff @(posedge wclk or negedge wresetn) begin
      if (!wresetn) rst_sync_q <= '0;
      else          rst_sync_q <= {rst_sync_q[0], 1'b1};
   end

   assign rst_n = rst_sync_q[1];

   state_e                state_q, state_d;
   logic [LW-1:0]         lane_q, lane_d;
   logic [DOUT_WIDTH-1:0] acc_q, acc_d;
   logic                  acc_pkt_q, acc_pkt_d;
   logic [DOUT_WIDTH-1:0] out_q, out_d;
   logic                  out_v_q, out_v_d;
   logic                  out_pkt_q, out_pkt_d;
   logic [31:0]           word_cnt_q, word_cnt_d;
   logic [15:0]           pkt_cnt_q, pkt_cnt_d;

   logic [DIN_WIDTH-1:0]  din;
   logic [DOUT_WIDTH-1:0] word;
   logic                  accept;
   logic                  close;
   logic                  out_free;

   always_comb begin
      din = s_axis_tdata;
`ifdef PACKER_BSWAP_EN
      for (int b = 0; b < DIN_WIDTH / 8; b++)
         din[b*8 +: 8] = s_axis_tdata[DIN_WIDTH-8-b*8 +: 8];
`endif
   end

   assign s_axis_tready = (state_q == ST_FILL);
   assign accept   = s_axis_tvalid & (state_q == ST_FILL);
   assign close    = accept & (s_axis_tlast | (lane_q == LAST_LANE));
   assign fifo_wen = out_v_q & ~fifo_full;
   assign out_free = ~out_v_q | ~fifo_full;

   // Accumulator with the current beat inserted; lanes above it are
   // padded when the beat ends the packet.
   always_comb begin
      word = acc_q;
      for (int i = 0; i < RATIO; i++) begin
         if (LW'(i) == lane_q)
            word[i*DIN_WIDTH +: DIN_WIDTH] = din;
         else if (s_axis_tlast && (LW'(i) > lane_q))
            word[i*DIN_WIDTH +: DIN_WIDTH] = PAD_WORD;
      end
   end

   always_comb begin
      state_d   = state_q;
      lane_d    = lane_q;
      acc_d     = acc_q;
      acc_pkt_d = acc_pkt_q;
      out_d     = out_q;
      out_v_d   = out_v_q & ~fifo_wen;
      out_pkt_d = out_pkt_q;
      unique case (state_q)
         ST_INIT: state_d = ST_FILL;
         ST_FILL: begin
            if (close && out_free) begin
               out_d     = word;
               out_v_d   = 1'b1;
               out_pkt_d = s_axis_tlast;
               lane_d    = '0;
            end else if (close) begin
               acc_d     = word;
               acc_pkt_d = s_axis_tlast;
               state_d   = ST_HOLD;
            end else if (accept) begin
               acc_d  = word;
               lane_d = lane_q + 1'b1;
            end
         end
         ST_HOLD: begin
            if (out_free) begin
               out_d     = acc_q;
               out_v_d   = 1'b1;
               out_pkt_d = acc_pkt_q;
               lane_d    = '0;
               state_d   = ST_FILL;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   assign word_cnt_d = word_cnt_q + 32'(fifo_wen);
   assign pkt_cnt_d  = pkt_cnt_q + 16'(fifo_wen & out_pkt_q);

   always_ff @(posedge wclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_INIT;
         lane_q     <= '0;
         acc_q      <= '0;
         acc_pkt_q  <= 1'b0;
         out_q      <= '0;
         out_v_q    <= 1'b0;
         out_pkt_q  <= 1'b0;
         word_cnt_q <= '0;
         pkt_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         lane_q     <= lane_d;
         acc_q      <= acc_d;
         acc_pkt_q  <= acc_pkt_d;
         out_q      <= out_d;
         out_v_q    <= out_v_d;
         out_pkt_q  <= out_pkt_d;
         word_cnt_q <= word_cnt_d;
         pkt_cnt_q  <= pkt_cnt_d;
      end
   end

   assign fifo_wdata = out_q;
   assign word_cnt   = word_cnt_q;
   assign pkt_cnt    = pkt_cnt_q;

endmodule
